// File: rtl/sr_ff_bank_if.sv
// rtl/sr_ff_bank_if.sv - control/status bundle for the sr_ff_bank channel array
interface sr_ff_bank_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic [N-1:0]     s;
    logic [N-1:0]     r;
    logic             conflict_clr;
    logic [N-1:0]     q;
    logic [N-1:0]     q_rise;
    logic [N-1:0]     q_fall;
    logic [N-1:0]     conflict_sticky;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output en, s, r, conflict_clr,
        input  q, q_rise, q_fall, conflict_sticky, conflict_cnt
    );

    modport slave (
        input  en, s, r, conflict_clr,
        output q, q_rise, q_fall, conflict_sticky, conflict_cnt
    );
endinterface

// File: rtl/sr_ff_bank.sv
// rtl/sr_ff_bank.sv - N-channel SR flip-flop bank with conflict policy, edge pulses and conflict tracking
module sr_ff_bank #(
    parameter int         N             = 4,
    parameter int         CONFLICT_MODE = 0,
    parameter logic [N-1:0] RESET_VAL   = '0,
    parameter int         CNT_W         = 8
) (
    input logic               clk,
    input logic               rst,
    sr_ff_bank_if.slave       bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     rise_q, rise_d;
    logic [N-1:0]     fall_q, fall_d;
    logic [N-1:0]     sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     event_vec;
    logic             any_event;

    // Conflicts only count while the bank is enabled.
    always_comb begin
        event_vec = bus.en ? (bus.s & bus.r) : '0;
        any_event = |event_vec;
    end

    always_comb begin
        q_d = q_q;
        if (bus.en) begin
            for (int i = 0; i < N; i++) begin
                case ({bus.s[i], bus.r[i]})
                    2'b01:   q_d[i] = 1'b0;
                    2'b10:   q_d[i] = 1'b1;
                    2'b11: begin
                        case (CONFLICT_MODE)
                            1:       q_d[i] = 1'b1;
                            2:       q_d[i] = 1'b0;
                            3:       q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
        rise_d = ~q_q & q_d;
        fall_d = q_q & ~q_d;
    end

    // A clear in the same cycle as a new event leaves only that event recorded.
    always_comb begin
        sticky_d = bus.conflict_clr ? event_vec : (sticky_q | event_vec);
        cnt_d    = cnt_q;
        if (bus.conflict_clr) begin
            cnt_d = any_event ? CNT_ONE : '0;
        end else if (any_event && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q      <= RESET_VAL;
            rise_q   <= '0;
            fall_q   <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            q_q      <= q_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.q               = q_q;
    assign bus.q_rise          = rise_q;
    assign bus.q_fall          = fall_q;
    assign bus.conflict_sticky = sticky_q;
    assign bus.conflict_cnt    = cnt_q;
endmodule
